busy_window_gen: RTL and testbench

- Drives a level `busy` window of programmed length for each accepted request; `busy` going low marks completion.
- Sits on the producer side of PE-array status lines, for consumers that recover completion by detecting the falling edge of a level.
- Guarantees at least one low cycle between consecutive windows, so every completion produces a detectable negedge.
- Emits a matching one-cycle `done` pulse and counts completed windows.

---
 rtl/busy_window_gen.sv | 101 ++++++++++
 tb/tb_busy_window_gen.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/busy_window_gen.sv
// Level busy-window generator: one busy window per accepted request, at least one low cycle between windows.
// Optional one-entry pending buffer enabled by defining BUSY_WIN_PENDING_EN.
module busy_window_gen #(
  parameter int LEN_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             drop,
  output logic [CNT_W-1:0] win_count
);

  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] cnt_nxt;
  logic [LEN_W-1:0] eff_len;
  logic [LEN_W-1:0] pend_len;
  logic             pend_v;
  logic             accept;

  assign eff_len = (len == '0) ? LEN_W'(1) : len;
  assign accept  = start && ready;

`ifdef BUSY_WIN_PENDING_EN
  // A request arriving mid-window is parked here and launched straight out of GAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_v   <= 1'b0;
      pend_len <= '0;
    end else if (accept && (state == RUN)) begin
      pend_v   <= 1'b1;
      pend_len <= eff_len;
    end else if ((state == GAP) && pend_v) begin
      pend_v   <= 1'b0;
    end
  end

  assign ready = (state == IDLE) || !pend_v;
`else
  assign pend_v   = 1'b0;
  assign pend_len = '0;
  assign ready    = (state == IDLE);
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = RUN;
          cnt_nxt   = eff_len;
        end
      end
      RUN: begin
        cnt_nxt = cnt - LEN_W'(1);
        if (cnt == LEN_W'(1)) state_nxt = GAP;
      end
      GAP: begin
        if (pend_v) begin
          state_nxt = RUN;
          cnt_nxt   = pend_len;
        end else if (accept) begin
          state_nxt = RUN;
          cnt_nxt   = eff_len;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are flopped from the next state so busy/done are clean registered levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      drop      <= 1'b0;
      win_count <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      busy  <= (state_nxt == RUN);
      done  <= (state_nxt == GAP);
      drop  <= start && !ready;
      if (state == GAP) win_count <= win_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_busy_window_gen.sv
// Directed self-checking bench for busy_window_gen; covers whichever BUSY_WIN_PENDING_EN build is compiled.
module tb_busy_window_gen;

  localparam int LEN_W = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             ready;
  logic             busy;
  logic             done;
  logic             drop;
  logic [CNT_W-1:0] win_count;

  int errors = 0;
  int checks = 0;
  int exp_win = 0;

  busy_window_gen #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .ready(ready),
    .busy(busy), .done(done), .drop(drop), .win_count(win_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic [LEN_W-1:0] l);
    start = s;
    len   = l;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [9:0] seq;
    int done_n;
    int drop_n;
    int n;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_drop", drop, 0);
    checkOutput("rst_win", win_count, 0);
    checkOutput("rst_ready", ready, 1);
    rst_n = 1'b1;
    stepCycle();

    // Basic len=3 window
    applyStimulus(1'b1, 8'd3);
    stepCycle();
    applyStimulus(1'b0, 8'd0);
    checkOutput("t1_busy_c1", busy, 1);
`ifdef BUSY_WIN_PENDING_EN
    checkOutput("t1_ready_run", ready, 1);
`else
    checkOutput("t1_ready_run", ready, 0);
`endif
    stepCycle();
    checkOutput("t1_busy_c2", busy, 1);
    stepCycle();
    checkOutput("t1_busy_c3", busy, 1);
    checkOutput("t1_done_c3", done, 0);
    stepCycle();
    checkOutput("t1_busy_c4", busy, 0);
    checkOutput("t1_done_c4", done, 1);
    checkOutput("t1_win_c4", win_count, 0);
    stepCycle();
    exp_win = 1;
    checkOutput("t1_done_c5", done, 0);
    checkOutput("t1_win_c5", win_count, exp_win);
    checkOutput("t1_ready_c5", ready, 1);

    // len=0 behaves as a one-cycle window
    applyStimulus(1'b1, 8'd0);
    stepCycle();
    applyStimulus(1'b0, 8'd0);
    checkOutput("t2_busy_c1", busy, 1);
    checkOutput("t2_drop_c1", drop, 0);
    stepCycle();
    checkOutput("t2_busy_c2", busy, 0);
    checkOutput("t2_done_c2", done, 1);
    checkOutput("t2_drop_c2", drop, 0);
    stepCycle();
    exp_win++;
    checkOutput("t2_done_c3", done, 0);
    checkOutput("t2_drop_c3", drop, 0);
    checkOutput("t2_win_c3", win_count, exp_win);

`ifdef BUSY_WIN_PENDING_EN
    // Back-to-back through the pending entry
    seq = '0; done_n = 0; drop_n = 0;
    applyStimulus(1'b1, 8'd2);
    for (int i = 1; i <= 8; i++) begin
      stepCycle();
      if (i == 1) applyStimulus(1'b1, 8'd4);
      else applyStimulus(1'b0, 8'd0);
      seq = {seq[8:0], busy};
      done_n += int'(done);
      drop_n += int'(drop);
    end
    checkOutput("t3_busy_seq", seq[7:0], 8'b11011110);
    checkOutput("t3_done_n", done_n, 2);
    checkOutput("t3_drop_n", drop_n, 0);
    stepCycle();
    exp_win += 2;
    checkOutput("t3_win", win_count, exp_win);

    // Third request while pending is full is dropped
    seq = '0; done_n = 0; drop_n = 0;
    applyStimulus(1'b1, 8'd3);
    for (int i = 1; i <= 10; i++) begin
      stepCycle();
      if (i == 1) begin
        applyStimulus(1'b1, 8'd2);
      end else if (i == 2) begin
        checkOutput("t4_ready_full", ready, 0);
        applyStimulus(1'b1, 8'd5);
      end else begin
        applyStimulus(1'b0, 8'd0);
      end
      if (i == 3) checkOutput("t4_drop_c3", drop, 1);
      seq = {seq[8:0], busy};
      done_n += int'(done);
      drop_n += int'(drop);
    end
    checkOutput("t4_busy_seq", seq, 10'b1110110000);
    checkOutput("t4_done_n", done_n, 2);
    checkOutput("t4_drop_n", drop_n, 1);
    exp_win += 2;
    checkOutput("t4_win", win_count, exp_win);

    // Start presented in the GAP cycle with pending empty
    seq = '0; done_n = 0;
    applyStimulus(1'b1, 8'd2);
    for (int i = 1; i <= 6; i++) begin
      stepCycle();
      if (i == 3) begin
        checkOutput("t5_ready_gap", ready, 1);
        applyStimulus(1'b1, 8'd1);
      end else begin
        applyStimulus(1'b0, 8'd0);
      end
      seq = {seq[8:0], busy};
      done_n += int'(done);
    end
    checkOutput("t5_busy_seq", seq[5:0], 6'b110100);
    checkOutput("t5_done_n", done_n, 2);
    exp_win += 2;
    checkOutput("t5_win", win_count, exp_win);
`else
    // Without the buffer, starts in RUN and GAP are dropped and the window is untouched
    seq = '0; done_n = 0; drop_n = 0;
    applyStimulus(1'b1, 8'd3);
    for (int i = 1; i <= 6; i++) begin
      stepCycle();
      if (i == 1) begin
        checkOutput("t3_ready_run", ready, 0);
        applyStimulus(1'b1, 8'd5);
      end else if (i == 4) begin
        checkOutput("t3_ready_gap", ready, 0);
        applyStimulus(1'b1, 8'd7);
      end else begin
        applyStimulus(1'b0, 8'd0);
      end
      if (i == 2) checkOutput("t3_drop_c2", drop, 1);
      if (i == 5) checkOutput("t3_drop_c5", drop, 1);
      seq = {seq[8:0], busy};
      done_n += int'(done);
      drop_n += int'(drop);
    end
    checkOutput("t3_busy_seq", seq[5:0], 6'b111000);
    checkOutput("t3_done_n", done_n, 1);
    checkOutput("t3_drop_n", drop_n, 2);
    exp_win += 1;
    checkOutput("t3_win", win_count, exp_win);
`endif

    // Maximum window length
    applyStimulus(1'b1, 8'd255);
    stepCycle();
    applyStimulus(1'b0, 8'd0);
    n = 0;
    while (busy && n < 400) begin
      n++;
      stepCycle();
    end
    checkOutput("tmax_len", n, 255);
    checkOutput("tmax_done", done, 1);
    stepCycle();
    exp_win++;
    checkOutput("tmax_win", win_count, exp_win);

    // Reset in the middle of a len=10 window
    applyStimulus(1'b1, 8'd10);
    stepCycle();
    applyStimulus(1'b0, 8'd0);
    repeat (4) stepCycle();
    checkOutput("trst_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("trst_busy", busy, 0);
    checkOutput("trst_done", done, 0);
    checkOutput("trst_win", win_count, 0);
    stepCycle();
    checkOutput("trst_done_held", done, 0);
    rst_n = 1'b1;
    stepCycle();
    checkOutput("trst_ready_rel", ready, 1);
    checkOutput("trst_win_rel", win_count, 0);
    checkOutput("trst_busy_rel", busy, 0);
    applyStimulus(1'b1, 8'd1);
    stepCycle();
    applyStimulus(1'b0, 8'd0);
    checkOutput("trst_busy_again", busy, 1);
    stepCycle();
    checkOutput("trst_done_again", done, 1);
    stepCycle();
    checkOutput("trst_win_again", win_count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
